// File: rtl/dsp_seq_pkg.sv
// Shared widths, FSM state type and the 18-bit saturation helper for the
// window sequencer and its MAC pipeline.
package dsp_seq_pkg;

    localparam int DATA_W  = 18;
    localparam int CNT_W   = 13;
    localparam int BRAM_AW = 10;
    localparam int HALF_AW = 9;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic signed [63:0] SAT_MAX = 64'sd131071;
    localparam logic signed [63:0] SAT_MIN = -64'sd131072;

    function automatic logic [DATA_W-1:0] sat18(input logic signed [63:0] v);
        logic [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = 18'h1FFFF;
        end else if (v < SAT_MIN) begin
            r = 18'h20000;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_window_sequencer_mac_pipe.sv
// Two-stage multiply-accumulate behind the BRAM read stage: registered product,
// then a Q-format accumulate onto a bias-preloaded accumulator.
module mac_pipe
    import dsp_seq_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     preload,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     pipe_busy,
    output logic [DATA_W-1:0]        sat_out
);

    localparam int PROD_W = 2 * DATA_W;

    logic                     v1;
    logic                     v2;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [63:0]       acc_64;

    assign a_ext    = {{DATA_W{a_data[DATA_W-1]}}, a_data};
    assign b_ext    = {{DATA_W{b_data[DATA_W-1]}}, b_data};
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    assign acc_64   = {{(64-ACC_W){acc[ACC_W-1]}}, acc};

    // Each product is rescaled (floor) before accumulation so acc stays in the operand Q-format.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            prod <= '0;
            acc  <= '0;
        end else begin
            v1   <= in_valid;
            v2   <= v1;
            prod <= a_ext * b_ext;
            if (preload) begin
                acc <= bias_ext;
            end else if (v2) begin
                acc <= acc + (prod_ext >>> FRAC_BITS);
            end
        end
    end

    assign pipe_busy = v1 | v2;
    assign sat_out   = sat18(acc_64);

endmodule

// File: rtl/dsp_window_sequencer.sv
// Consumer side of the shared operand/tap BRAM: issues paired reads while both
// halves have unconsumed entries and emits one saturated MAC result per window.
module dsp_window_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   filter_length,
    input  logic [DATA_W-1:0]  filter_bias,
    input  logic [CNT_W-1:0]   issue_a_alloc_counter,
    input  logic [CNT_W-1:0]   filter_issue_counter,
    output logic               ramb_rd_en,
    output logic [BRAM_AW-1:0] ramb_a_addr,
    output logic [BRAM_AW-1:0] ramb_b_addr,
    input  logic [DATA_W-1:0]  ramb_a_data,
    input  logic [DATA_W-1:0]  ramb_b_data,
    output logic [CNT_W-1:0]   issue_a_dsp_counter,
    output logic [CNT_W-1:0]   filter_dsp_counter,
    output logic               busy,
    output logic               result_ready,
    output logic [DATA_W-1:0]  result_data
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  length_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  diff_a;
    logic [CNT_W-1:0]  diff_b;
    logic              avail_a;
    logic              avail_b;
    logic              pipe_busy;
    logic              run_done;
    logic              accept;
    logic              fire;
    logic              done;
    logic [DATA_W-1:0] sat_out;

    // Modular differences keep availability correct across 13-bit counter wrap.
    assign diff_a   = issue_a_alloc_counter - issue_a_dsp_counter;
    assign diff_b   = filter_issue_counter - filter_dsp_counter;
    assign avail_a  = (diff_a != '0);
    assign avail_b  = (diff_b != '0);
    assign run_done = (issued == length_q) && !pipe_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (run_done) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        fire   = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE: accept = start;
            RUN: begin
                busy = 1'b1;
                fire = (issued < length_q) && avail_a && avail_b;
                done = run_done;
            end
            default: ;
        endcase
    end

    assign ramb_rd_en  = fire;
    assign ramb_a_addr = {1'b0, issue_a_dsp_counter[HALF_AW-1:0]};
    assign ramb_b_addr = {1'b1, filter_dsp_counter[HALF_AW-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            length_q            <= '0;
            issued              <= '0;
            issue_a_dsp_counter <= '0;
            filter_dsp_counter  <= '0;
            result_ready        <= 1'b0;
            result_data         <= '0;
        end else begin
            result_ready <= done;
            if (accept) begin
                length_q <= filter_length;
                issued   <= '0;
            end
            if (fire) begin
                issued              <= issued + 1'b1;
                issue_a_dsp_counter <= issue_a_dsp_counter + 1'b1;
                filter_dsp_counter  <= filter_dsp_counter + 1'b1;
            end
            if (done) begin
                result_data <= sat_out;
            end
        end
    end

    mac_pipe #(
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac_pipe (
        .clk       (clk),
        .rst       (rst),
        .preload   (accept),
        .bias      (filter_bias),
        .in_valid  (fire),
        .a_data    (ramb_a_data),
        .b_data    (ramb_b_data),
        .pipe_busy (pipe_busy),
        .sat_out   (sat_out)
    );

endmodule
